// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the SRAM controller.
package sram_ctrl_pkg;
  localparam int WORD_SIZE = 32;
  localparam int BE_WIDTH = WORD_SIZE / 8;
  typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RMW_RD, RMW_MERGE, RMW_WR} state_e;
  typedef enum logic {LSU, LOADER} grant_e;
endpackage

// File: rtl/sram_byte_merge.sv
// sram_byte_merge: per-byte select between an old word and a new word.
module sram_byte_merge
  import sram_ctrl_pkg::*;
(
  input  logic [WORD_SIZE-1:0] i_old,
  input  logic [WORD_SIZE-1:0] i_new,
  input  logic [BE_WIDTH-1:0]  i_be,
  output logic [WORD_SIZE-1:0] o_merged
);
  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_byte
    assign o_merged[8*i +: 8] = i_be[i] ? i_new[8*i +: 8] : i_old[8*i +: 8];
  end
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: fetch path on port A, round-robin LSU/loader access to port B and write port with RMW.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int num_words    = 4096,
  parameter int l2_num_words = $clog2(num_words)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_if_req,
  input  logic [l2_num_words-1:0] i_if_addr,
  output logic                    o_if_ready,
  output logic                    o_if_valid,
  output logic [WORD_SIZE-1:0]    o_if_data,
  input  logic                    i_ls_req,
  input  logic                    i_ls_we,
  input  logic [l2_num_words-1:0] i_ls_addr,
  input  logic [WORD_SIZE-1:0]    i_ls_wdata,
  input  logic [BE_WIDTH-1:0]     i_ls_be,
  output logic                    o_ls_ready,
  output logic                    o_ls_valid,
  output logic [WORD_SIZE-1:0]    o_ls_rdata,
  input  logic                    i_ld_req,
  input  logic [l2_num_words-1:0] i_ld_addr,
  input  logic [WORD_SIZE-1:0]    i_ld_wdata,
  output logic                    o_ld_ready,
  output logic                    o_sram_re_A,
  output logic [l2_num_words-1:0] o_sram_addr_A,
  input  logic [WORD_SIZE-1:0]    i_sram_data_A,
  output logic                    o_sram_re_B,
  output logic [l2_num_words-1:0] o_sram_addr_B,
  input  logic [WORD_SIZE-1:0]    i_sram_data_B,
  output logic                    o_sram_we,
  output logic [l2_num_words-1:0] o_sram_addr_w,
  output logic [WORD_SIZE-1:0]    o_sram_wdata
);
  state_e                  state_q, state_d;
  grant_e                  last_q, last_d;
  logic [l2_num_words-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d, merged;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic                    is_ls_q, is_ls_d;
  logic                    re_b_q, re_b_d, we_q, we_d, ls_valid_q, ls_valid_d, if_valid_q, if_valid_d;
  logic                    grant_ls, grant_ld;

  sram_byte_merge u_merge (
    .i_old    (i_sram_data_B),
    .i_new    (wdata_q),
    .i_be     (be_q),
    .o_merged (merged)
  );

  always_comb begin
    grant_ls   = state_q == IDLE && !i_rst && i_ls_req && (!i_ld_req || last_q == LOADER);
    grant_ld   = state_q == IDLE && !i_rst && i_ld_req && !grant_ls;
    state_d    = state_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    is_ls_d    = is_ls_q;
    if_valid_d = i_if_req && !i_rst;
    if (grant_ls) begin
      last_d  = LSU;
      addr_d  = i_ls_addr;
      wdata_d = i_ls_wdata;
      be_d    = i_ls_be;
      is_ls_d = 1'b1;
      state_d = !i_ls_we ? RD : (&i_ls_be || ~|i_ls_be) ? WR : RMW_RD;
    end else if (grant_ld) begin
      last_d  = LOADER;
      addr_d  = i_ld_addr;
      wdata_d = i_ld_wdata;
      be_d    = '1;
      is_ls_d = 1'b0;
      state_d = WR;
    end else if (state_q != IDLE) begin
      state_d = state_q == RD ? RD_DATA : state_q == RMW_RD ? RMW_MERGE : state_q == RMW_MERGE ? RMW_WR : IDLE;
      wdata_d = state_q == RMW_MERGE ? merged : wdata_q;
    end
    // Strobes are registered off the next state, so each lands in the cycle its state is entered.
    re_b_d     = state_d == RD || state_d == RMW_RD;
    we_d       = (state_d == WR && &be_d) || state_d == RMW_WR;
    ls_valid_d = (state_d == WR && is_ls_d) || state_d == RD_DATA || state_d == RMW_WR;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_q     <= LOADER;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      is_ls_q    <= 1'b0;
      re_b_q     <= 1'b0;
      we_q       <= 1'b0;
      ls_valid_q <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      is_ls_q    <= is_ls_d;
      re_b_q     <= re_b_d;
      we_q       <= we_d;
      ls_valid_q <= ls_valid_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign o_if_ready    = !i_rst;
  assign o_sram_re_A   = i_if_req && !i_rst;
  assign o_sram_addr_A = i_if_addr;
  assign o_if_valid    = if_valid_q;
  assign o_if_data     = if_valid_q ? i_sram_data_A : '0;
  assign o_ls_ready    = grant_ls;
  assign o_ld_ready    = grant_ld;
  assign o_ls_valid    = ls_valid_q;
  assign o_ls_rdata    = state_q == RD_DATA ? i_sram_data_B : '0;
  assign o_sram_re_B   = re_b_q;
  assign o_sram_addr_B = addr_q;
  assign o_sram_we     = we_q;
  assign o_sram_addr_w = addr_q;
  assign o_sram_wdata  = wdata_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: vector table, directed corner sequences and random traffic against a memory model.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 0, ls_req = 0, ls_we = 0, ld_req = 0;
  logic [11:0] if_addr = 0, ls_addr = 0, ld_addr = 0;
  logic [31:0] ls_wdata = 0, ld_wdata = 0;
  logic [3:0]  ls_be = 0;
  logic        if_ready, if_valid, ls_ready, ls_valid, ld_ready, re_a, re_b, we;
  logic [31:0] if_data, ls_rdata, data_a, data_b, wdata;
  logic [11:0] addr_a, addr_b, addr_w;
  logic        pl_we = 0;
  logic [11:0] pl_addr = 0;
  logic [31:0] pl_data = 0;
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  int n_cmp = 0, n_fail = 0, we_cnt = 0;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [10];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re_a) data_a <= mem[addr_a];
    if (re_b) data_b <= mem[addr_b];
    if (we) mem[addr_w] <= wdata;
    if (pl_we) mem[pl_addr] <= pl_data;
    if (we) we_cnt <= we_cnt + 1;
  end

  sram_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready), .o_if_valid(if_valid), .o_if_data(if_data),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata), .i_ls_be(ls_be),
    .o_ls_ready(ls_ready), .o_ls_valid(ls_valid), .o_ls_rdata(ls_rdata),
    .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .o_ld_ready(ld_ready),
    .o_sram_re_A(re_a), .o_sram_addr_A(addr_a), .i_sram_data_A(data_a),
    .o_sram_re_B(re_b), .o_sram_addr_B(addr_b), .i_sram_data_B(data_b),
    .o_sram_we(we), .o_sram_addr_w(addr_w), .o_sram_wdata(wdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (nw & m) | (old & ~m);
  endfunction

  task automatic do_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask

  task automatic ls_txn(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd);
    bit acc, got;
    acc = 0;
    got = 0;
    rd = 'x;
    ls_req = 1; ls_we = w; ls_addr = a; ls_wdata = d; ls_be = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (ls_ready) acc = 1;
      tick;
    end
    ls_req = 0;
    chk("ls_accept", 32'(acc), 1);
    for (int i = 0; i < 8 && acc && !got; i++) begin
      if (ls_valid) begin
        got = 1;
        rd = ls_rdata;
      end else tick;
    end
    chk("ls_valid_seen", 32'(got), 1);
    tick;
    chk("ls_valid_pulse", 32'(ls_valid), 0);
    if (w) ref_mem[a] = merge_ref(ref_mem[a], d, b);
  endtask

  task automatic ld_txn(input logic [11:0] a, input logic [31:0] d);
    bit acc;
    acc = 0;
    ld_req = 1; ld_addr = a; ld_wdata = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (ld_ready) acc = 1;
      tick;
    end
    ld_req = 0;
    chk("ld_accept", 32'(acc), 1);
    ref_mem[a] = d;
  endtask

  initial begin
    logic [31:0] rd;
    int g [6];
    int ng, w0;
    vt[0] = '{1'b1, 12'h020, 32'hA5A5A5A5, 4'hF, 32'h0};
    vt[1] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'hA5A5A5A5};
    vt[2] = '{1'b1, 12'h020, 32'h000000FF, 4'h1, 32'h0};
    vt[3] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'hA5A5A5FF};
    vt[4] = '{1'b1, 12'h020, 32'h11220000, 4'hC, 32'h0};
    vt[5] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h1122A5FF};
    vt[6] = '{1'b1, 12'h020, 32'h77000088, 4'h9, 32'h0};
    vt[7] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h7722A588};
    vt[8] = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 32'h0};
    vt[9] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h7722A588};
    // preload words 0..63 while reset is held
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (i == 'h10) ? 32'hDEADBEEF : $urandom;
      pl_we = 1; pl_addr = 12'(i); pl_data = ref_mem[i];
      tick;
    end
    pl_we = 0;
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_ls_valid", 32'(ls_valid), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_re_b", 32'(re_b), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_wdata", wdata, 0);
    rst = 0;
    #1;
    chk("if_ready", 32'(if_ready), 1);
    // fetch: single then back-to-back
    if_req = 1; if_addr = 12'h010;
    #1;
    chk("if_re_a", 32'(re_a), 1);
    chk("if_addr_a", 32'(addr_a), 32'h010);
    tick;
    chk("if_valid0", 32'(if_valid), 1);
    chk("if_data0", if_data, 32'hDEADBEEF);
    if_addr = 12'h011;
    tick;
    chk("if_valid1", 32'(if_valid), 1);
    chk("if_data1", if_data, ref_mem['h11]);
    if_req = 0;
    tick;
    chk("if_valid_off", 32'(if_valid), 0);
    // full write then read with exact latencies
    ls_req = 1; ls_we = 1; ls_addr = 12'h004; ls_wdata = 32'h12345678; ls_be = 4'hF;
    #1;
    chk("wr_ready", 32'(ls_ready), 1);
    tick;
    ls_req = 0;
    chk("wr_we", 32'(we), 1);
    chk("wr_addr", 32'(addr_w), 32'h004);
    chk("wr_wdata", wdata, 32'h12345678);
    chk("wr_valid", 32'(ls_valid), 1);
    chk("wr_ack_rdata", ls_rdata, 0);
    ref_mem[4] = 32'h12345678;
    tick;
    ls_req = 1; ls_we = 0;
    #1;
    chk("rd_ready", 32'(ls_ready), 1);
    tick;
    ls_req = 0;
    chk("rd_re_b", 32'(re_b), 1);
    chk("rd_valid_early", 32'(ls_valid), 0);
    tick;
    chk("rd_valid", 32'(ls_valid), 1);
    chk("rd_data", ls_rdata, 32'h12345678);
    tick;
    // partial write read-modify-write
    ls_req = 1; ls_we = 1; ls_be = 4'b0010; ls_wdata = 32'h0000AB00;
    #1;
    chk("rmw_ready", 32'(ls_ready), 1);
    tick;
    ls_req = 0;
    chk("rmw_re_b", 32'(re_b), 1);
    chk("rmw_addr_b", 32'(addr_b), 32'h004);
    chk("rmw_we1", 32'(we), 0);
    tick;
    chk("rmw_we2", 32'(we), 0);
    chk("rmw_valid2", 32'(ls_valid), 0);
    chk("rmw_busy_ready", 32'(ls_ready), 0);
    tick;
    chk("rmw_we3", 32'(we), 1);
    chk("rmw_wdata", wdata, 32'h1234AB78);
    chk("rmw_addr_w", 32'(addr_w), 32'h004);
    chk("rmw_valid3", 32'(ls_valid), 1);
    ref_mem[4] = 32'h1234AB78;
    tick;
    // zero byte enables: ack without write
    w0 = we_cnt;
    ls_req = 1; ls_we = 1; ls_addr = 12'h004; ls_be = 4'h0; ls_wdata = 32'hFFFFFFFF;
    #1;
    tick;
    ls_req = 0;
    chk("be0_valid", 32'(ls_valid), 1);
    chk("be0_we", 32'(we), 0);
    tick;
    chk("be0_we_cnt", we_cnt, w0);
    ls_txn(0, 12'h004, 0, 0, rd);
    chk("be0_mem", rd, 32'h1234AB78);
    // vector table
    for (int i = 0; i < 10; i++) begin
      ls_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd);
      chk($sformatf("vec%0d", i), rd, vt[i].exp);
    end
    // reset during merge drops the transaction
    w0 = we_cnt;
    ls_req = 1; ls_we = 1; ls_addr = 12'h005; ls_be = 4'b0100; ls_wdata = 32'h00990000;
    #1;
    tick;
    ls_req = 0;
    tick;
    rst = 1;
    tick;
    chk("rstm_we", 32'(we), 0);
    chk("rstm_valid", 32'(ls_valid), 0);
    chk("rstm_ready_in_rst", 32'(ls_ready), 0);
    rst = 0;
    ls_req = 1; ls_we = 0;
    #1;
    chk("rstm_ready_after", 32'(ls_ready), 1);
    ls_txn(0, 12'h005, 0, 0, rd);
    chk("rstm_mem", rd, ref_mem[5]);
    chk("rstm_we_cnt", we_cnt, w0);
    // fairness under continuous contention
    do_reset;
    ls_req = 1; ls_we = 0; ls_addr = 12'h030;
    ld_req = 1; ld_addr = 12'h031; ld_wdata = 32'hC0FFEE00;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      chk("ready_exclusive", 32'(ls_ready & ld_ready), 0);
      if (ls_ready) g[ng++] = 0;
      else if (ld_ready) g[ng++] = 1;
      tick;
    end
    ls_req = 0;
    ld_req = 0;
    ref_mem['h31] = 32'hC0FFEE00;
    chk("grant_count", ng, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("grant%0d", k), g[k], k % 2);
    for (int i = 0; i < 4; i++) tick;
    // random traffic against the reference memory
    for (int n = 0; n < 250; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = 12'($urandom_range(0, 63));
      d = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          ls_txn(0, a, 0, 0, rd);
          chk("rnd_rd", rd, ref_mem[a]);
        end
        1: begin
          ls_txn(1, a, d, 4'($urandom_range(0, 15)), rd);
          chk("rnd_wr_ack", rd, 0);
        end
        2: ld_txn(a, d);
        default: begin
          tick;
          if_req = 1; if_addr = a;
          tick;
          if_req = 0;
          chk("rnd_if", if_data, ref_mem[a]);
        end
      endcase
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
